// File: rtl/matrix_loader.sv
// Streams 2*DIM*DIM signed bytes (A then B, row-major) into packed operand buses; out_valid on the last accepting edge.
// Stalls input (in_ready=0) while holding a completed frame until out_ack. Optional abort port: MATRIX_LOADER_ABORT_EN.
module matrix_loader #(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [2:0]             op_cfg,
    output logic                   out_valid,
    input  logic                   out_ack,
`ifdef MATRIX_LOADER_ABORT_EN
    input  logic                   abort,
`endif
    output logic [DIM*DIM*W-1:0]   Aa,
    output logic [DIM*DIM*W-1:0]   Bb,
    output logic [2:0]             op,
    output logic [7:0]             frames_done
);

    localparam int N  = DIM * DIM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [2:0]    op_q;
    logic          abort_i;
    logic          xfer;

`ifdef MATRIX_LOADER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign in_ready = (state == LOAD_A || state == LOAD_B) && !rst;
    // An aborting edge never consumes a byte, even with a valid handshake.
    assign xfer     = in_valid && in_ready && !abort_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD_A;
            idx         <= '0;
            Aa          <= '0;
            Bb          <= '0;
            op_q        <= 3'b000;
            op          <= 3'b000;
            out_valid   <= 1'b0;
            frames_done <= 8'd0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (abort_i) begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end else if (xfer) begin
                        Aa[int'(idx)*W +: W] <= in_data;
                        if (idx == '0) op_q <= op_cfg;
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (abort_i) begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end else if (xfer) begin
                        Bb[int'(idx)*W +: W] <= in_data;
                        if (idx == LAST) begin
                            idx         <= '0;
                            state       <= HOLD;
                            out_valid   <= 1'b1;
                            op          <= op_q;
                            frames_done <= frames_done + 8'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack || abort_i) begin
                        state     <= LOAD_A;
                        out_valid <= 1'b0;
                        op        <= 3'b000;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    idx       <= '0;
                    out_valid <= 1'b0;
                    op        <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: table-driven frames with a scoreboard of expected operands, plus hold/reset/wrap/abort sequences.
module tb_matrix_loader;
    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int N   = DIM * DIM;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [2:0]       op_cfg;
    logic             out_valid;
    logic             out_ack;
    logic [N*W-1:0]   Aa;
    logic [N*W-1:0]   Bb;
    logic [2:0]       op;
    logic [7:0]       frames_done;
`ifdef MATRIX_LOADER_ABORT_EN
    logic             abort;
`endif

    always #5 clk = ~clk;

    matrix_loader #(.DIM(DIM), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .op_cfg      (op_cfg),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
`ifdef MATRIX_LOADER_ABORT_EN
        .abort       (abort),
`endif
        .Aa          (Aa),
        .Bb          (Bb),
        .op          (op),
        .frames_done (frames_done)
    );

    typedef struct {
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [2:0]     op;
        logic [7:0]     fd;
    } exp_t;

    typedef struct {
        int         pat;
        int         gap;
        logic [2:0] opc;
        logic [7:0] exp_fd;
    } vec_t;

    exp_t         sb[$];
    vec_t         vt[5];
    logic [W-1:0] da[2*N];
    logic [7:0]   fd_model = 8'd0;
    int           checks   = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic gen(input int pat);
        for (int k = 0; k < 2*N; k++) begin
            if (pat == 0) da[k] = (k < N) ? W'(k) : W'(-(k - N));
            else          da[k] = W'($urandom);
        end
    endtask

    task automatic push_exp(input logic [2:0] opc);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.a[k*W +: W] = da[k];
            e.b[k*W +: W] = da[N + k];
        end
        e.op = opc;
        fd_model = fd_model + 8'd1;
        e.fd = fd_model;
        sb.push_back(e);
    endtask

    // Drives the first n bytes of da; gap inserts an idle cycle before every odd byte.
    task automatic send_bytes(input int n, input int gap, input logic [2:0] opc);
        bit acc;
        op_cfg = opc;
        for (int k = 0; k < n; k++) begin
            if (gap != 0 && (k % 2) == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
            end
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = da[k];
                acc      = in_ready;
                @(posedge clk);
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL send_timeout byte=%0d actual=in_ready_low required=accept", k);
                return;
            end
            #1;
            if (n == 2*N && k >= 2*N - 2) chk("out_valid_edge", N*W'(out_valid), N*W'(k == 2*N - 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_out();
        exp_t e;
        bit   seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL out_timeout actual=out_valid_%0b,queued_%0d required=out_valid_1,queued_1", seen, sb.size());
            return;
        end
        e = sb.pop_front();
        chk("Aa", Aa, e.a);
        chk("Bb", Bb, e.b);
        chk("op", N*W'(op), N*W'(e.op));
        chk("frames_done", N*W'(frames_done), N*W'(e.fd));
    endtask

    task automatic do_ack();
        @(negedge clk);
        out_ack = 1'b1;
        chk("in_ready_in_ack", N*W'(in_ready), '0);
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        chk("out_valid_after_ack", N*W'(out_valid), '0);
        chk("op_after_ack", N*W'(op), '0);
    endtask

    task automatic frame(input int pat, input int gap, input logic [2:0] opc);
        gen(pat);
        push_exp(opc);
        send_bytes(2*N, gap, opc);
        check_out();
        do_ack();
    endtask

    logic [N*W-1:0] held;

    initial begin
        vt[0] = '{pat: 0, gap: 0, opc: 3'b010, exp_fd: 8'd1};
        vt[1] = '{pat: 0, gap: 1, opc: 3'b010, exp_fd: 8'd2};
        vt[2] = '{pat: 1, gap: 0, opc: 3'b111, exp_fd: 8'd3};
        vt[3] = '{pat: 1, gap: 1, opc: 3'b101, exp_fd: 8'd4};
        vt[4] = '{pat: 1, gap: 0, opc: 3'b000, exp_fd: 8'd5};

        rst = 1'b1; in_valid = 1'b0; out_ack = 1'b0; in_data = '0; op_cfg = 3'b000;
`ifdef MATRIX_LOADER_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_in_ready", N*W'(in_ready), '0);
        chk("rst_out_valid", N*W'(out_valid), '0);
        chk("rst_Aa", Aa, '0);
        chk("rst_Bb", Bb, '0);
        chk("rst_op", N*W'(op), '0);
        chk("rst_frames", N*W'(frames_done), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", N*W'(in_ready), N*W'(1'b1));

        // Table-driven frames; row 0 is the plain ramp stream
        for (int i = 0; i < 5; i++) begin
            gen(vt[i].pat);
            push_exp(vt[i].opc);
            send_bytes(2*N, vt[i].gap, vt[i].opc);
            check_out();
            chk("tbl_frames", N*W'(frames_done), N*W'(vt[i].exp_fd));
            chk("tbl_op", N*W'(op), N*W'(vt[i].opc));
            if (i == 0) begin
                chk("Aa_e0", N*W'(Aa[7:0]), '0);
                chk("Aa_e24", N*W'(Aa[199:192]), N*W'(8'd24));
                chk("Bb_e1", N*W'(Bb[15:8]), N*W'(8'hFF));
            end
            do_ack();
        end

        // Offer bytes throughout HOLD and the ack cycle; none may land
        gen(0);
        push_exp(3'b011);
        send_bytes(2*N, 0, 3'b011);
        check_out();
        held = sb.size() == 0 ? Aa : Aa;
        held = '0;
        for (int k = 0; k < N; k++) held[k*W +: W] = W'(k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hEE;
            chk("hold_in_ready", N*W'(in_ready), '0);
            @(posedge clk);
            #1;
            chk("hold_Aa", Aa, held);
        end
        do_ack();
        chk("ack_no_write", N*W'(Aa[7:0]), '0);
        chk("ready_after_ack", N*W'(in_ready), N*W'(1'b1));
        frame(1, 0, 3'b100);

        // Asynchronous reset mid-frame
        gen(0);
        send_bytes(30, 0, 3'b011);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_Aa", Aa, '0);
        chk("arst_Bb", Bb, '0);
        chk("arst_frames", N*W'(frames_done), '0);
        chk("arst_op", N*W'(op), '0);
        chk("arst_in_ready", N*W'(in_ready), '0);
        @(negedge clk);
        rst = 1'b0;
        fd_model = 8'd0;
        sb.delete();
        frame(0, 0, 3'b001);

`ifdef MATRIX_LOADER_ABORT_EN
        gen(1);
        send_bytes(10, 0, 3'b011);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        chk("abort_in_ready", N*W'(in_ready), N*W'(1'b1));
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        frame(1, 1, 3'b110);
`endif

        // frames_done wraps after 256 frames from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fd_model = 8'd0;
        sb.delete();
        for (int f = 0; f < 256; f++) frame(1, 0, 3'($urandom));
        chk("wrap_frames", N*W'(frames_done), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
Upstream stage of the ULA matrix multiplier. Accepts a stream of signed 8-bit elements over a valid/ready handshake and assembles two DIMxDIM operand matrices in packed-bus form (Aa, Bb). It then presents them, with the captured opcode, to the multiplier. It holds the operands and opcode stable until the consumer acknowledges, then re-arms for the next frame.

Parameters:
DIM, 5, matrix dimension (rows = columns)
W, 8, element width in bits (signed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  element byte present on in_data
in_ready  output  1  loader can accept an element this cycle
in_data  input  W  signed element, row-major order, A first then B
op_cfg  input  3  ULA opcode for this frame; sampled with first A element
out_valid  output  1  Aa/Bb/op complete and stable
out_ack  input  1  consumer has taken the operands
Aa  output  DIM*DIM*W  matrix A, element (i,j) at [(DIM*i+j)*W +: W]
Bb  output  DIM*DIM*W  matrix B, same packing
op  output  3  opcode to ULA; 3'b000 unless out_valid
frames_done  output  8  count of completed frames, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=LOAD_A, idx=0, Aa=0, Bb=0, op_q=0, op=0, out_valid=0, frames_done=0. in_ready=0 while rst is high.
- A transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = (state==LOAD_A || state==LOAD_B) && !rst. It is combinational from state; no dependency on in_valid.
- LOAD_A:
  - Each transfer writes in_data to Aa[idx*W +: W], idx++.
  - The transfer at idx==0 also latches op_q<=op_cfg.
  - The transfer at idx==DIM*DIM-1 sets idx<=0 and moves to LOAD_B.
- LOAD_B:
  - Each transfer writes Bb[idx*W +: W], idx++.
  - The transfer at idx==DIM*DIM-1 sets idx<=0, moves to HOLD, out_valid<=1, frames_done++.
- HOLD:
  - in_ready=0. Aa, Bb and op=op_q are held unchanged.
  - out_ack high at an edge moves to LOAD_A; out_valid<=0 and op<=0 on the same edge.
  - A byte offered in the ack cycle is not accepted (in_ready still 0). It is accepted at the earliest on the next edge.
- Latency: out_valid rises on the edge that accepts the 2*DIM*DIM-th byte. Minimum frame is 2*DIM*DIM cycles plus 1 ack cycle.
- op is registered; op==3'b000 in LOAD_A/LOAD_B, so the downstream multiplier drives zero while operands are changing.
- Aa/Bb retain their previous frame values until overwritten element by element. No clear between frames.
- out_ack outside HOLD is ignored.
- in_valid gaps (bubbles) are allowed anywhere; idx does not advance without a transfer.
- idx is ceil(log2(DIM*DIM)) bits and never exceeds DIM*DIM-1.
- Reset mid-frame: partial data is discarded, all outputs return to reset values immediately (async).
- in_data is stored as raw two's-complement bits; no saturation or sign conversion in this block.

Optional Feature:
MATRIX_LOADER_ABORT_EN
- Defined: adds input port abort (1 bit).
  - In LOAD_A/LOAD_B, abort high at an edge sets idx<=0 and state<=LOAD_A. No byte is accepted that edge, even if in_valid && in_ready. Aa/Bb keep their partial contents; op_q is re-latched on the next first byte.
  - In HOLD, abort behaves exactly as out_ack.
  - frames_done is not incremented by an aborted frame.
- Undefined: no abort port; frame can only be cancelled by rst.

Test Plan:
1. Reset then stream 50 bytes, back-to-back, values A(k)=k, B(k)=-k, op_cfg=3'b010 -> out_valid=1 on the 50th accepting edge. Aa[7:0]=0, Aa[199:192]=24, Bb[15:8]=8'hFF, op=3'b010, frames_done=1.
2. Same stream with in_valid low every other cycle -> identical Aa/Bb/op. out_valid rises only after the 50th transfer; idx never skips.
3. In HOLD, hold in_valid=1 for 5 cycles, then pulse out_ack -> no transfers during HOLD or the ack cycle. Next edge accepts A(0); op=0 and out_valid=0 the edge after ack.
4. Assert rst asynchronously after 30 bytes -> outputs zero without a clock edge. A fresh 50-byte frame with op_cfg=3'b001 loads correctly and frames_done=1.
5. Run 256 frames -> frames_done wraps from 255 to 0 on the 256th frame.
6. (MATRIX_LOADER_ABORT_EN) abort with in_valid high after 10 A bytes -> byte not taken, idx=0. The following 50 bytes form a valid frame and frames_done increments by exactly 1.
